game_loop_seq: RTL and testbench
================================

# game_loop_seq

Parametrised top-level game-loop sequencer for the Tetris core, replacing the fixed seven-piece loop. It walks a generated piece bag of configurable size, spawns each piece, and arbitrates player moves against gravity ticks. It also commands the piece lock, optionally with a lock delay, and detects game over when a spawned piece overlaps the grid. It drives the piece-order generator, the piece/grid updater and the display FSMs.

## Interface
- BAG_SIZE, 7: pieces per generated bag (2..2**INDEX_W).
- INDEX_W, 3: width of bag index.
- LOCK_TICKS, 2: gravity ticks a landed piece waits before locking (only with lock delay; ≥1).
- CNT_W, 16: width of placed-piece counter.

Ports:
- clk  in  1  system clock; one clock, all logic on rising edge.
- iReset  in  1  synchronous, active-high reset.
- iEn  in  1  global enable; low freezes all state.
- iMoveRight, iMoveLeft, iMoveDown, iRotate  in  1 each  player requests (level, sampled in IDLE).
- iGravityTick  in  1  one-cycle gravity pulse.
- iLanded  in  1  piece cannot move down further.
- iPieceBlockOverlap  in  1  spawned piece overlaps settled blocks.
- iGenDone  in  1  bag generation finished.
- iUpdateDone  in  1  updater finished current update/lock.
- oGeneratePieceOrder  out  1  request new bag.
- oResetPiecePosition  out  1  spawn piece at (col,row)=(4,0).
- oUpdatePiece  out  1  apply pending move/rotate/drop.
- oGravityDrop  out  1  one-cycle pulse: the update is a gravity step.
- oLockPiece  out  1  merge piece into grid and clear lines.
- oIndex  out  INDEX_W  current bag position.
- oPiecesPlaced  out  CNT_W  pieces locked since reset.
- oGameOver  out  1  sticky game-over flag.

## Operation
- States: GEN, SPAWN, CHECK, UPDATE, IDLE, LOCK, ADVANCE, OVER. Outputs are Moore decodes of state, except oGravityDrop.
- GEN: oGeneratePieceOrder=1, index held 0; iGenDone → SPAWN.
- SPAWN: oResetPiecePosition=1 for one cycle → CHECK.
- CHECK: samples iPieceBlockOverlap. 1 → OVER, 0 → UPDATE.
- UPDATE: oUpdatePiece=1 until iUpdateDone → IDLE.
- IDLE priority, highest first:
  - any move/rotate request → UPDATE;
  - iGravityTick & !iLanded → UPDATE, with oGravityDrop=1 in that same cycle;
  - iGravityTick & iLanded → lock decision (see Configuration);
  - otherwise stay in IDLE.
- LOCK: oLockPiece=1 until iUpdateDone → ADVANCE.
- ADVANCE (one cycle): oPiecesPlaced+1 (wraps at 2**CNT_W).
  - If oIndex==BAG_SIZE-1: oIndex←0 → GEN.
  - Else: oIndex+1 → SPAWN.
- OVER: oGameOver=1. All other outputs 0; inputs ignored until iReset.
- iEn low: state, index, counters frozen; all pulse/request outputs forced 0; oIndex, oPiecesPlaced, oGameOver keep their registered values.
- iReset has priority over iEn.

## Timing
- Reset values: state GEN, oIndex 0, oPiecesPlaced 0, lock counter 0, oGameOver 0, all request outputs 0. oGeneratePieceOrder rises in the first cycle after reset deasserts.
- Reset mid-operation (any state, including OVER) → GEN on the next edge; no partial lock is completed.
- iGenDone→oResetPiecePosition: 1 cycle. Spawn→first oUpdatePiece: 2 cycles (SPAWN, CHECK).
- iUpdateDone is honoured only in UPDATE/LOCK; the transition happens on the same edge it is sampled.
- Move and gravity tick in the same IDLE cycle: the move wins; the tick is dropped (not queued).
- Requests are ignored outside IDLE.
- Lock→next spawn: iUpdateDone edge → ADVANCE (1 cycle) → SPAWN. At bag end, the path goes through GEN instead.

## Configuration
- GL_LOCK_DELAY_EN defined:
  - A LOCK_TICKS-range counter counts iGravityTick pulses seen in IDLE while iLanded=1.
  - When a tick arrives with counter==LOCK_TICKS-1 → LOCK.
  - The counter clears on any accepted move/rotate, when iLanded=0 in IDLE, and in ADVANCE.
- Undefined: no counter; the first iGravityTick in IDLE with iLanded=1 → LOCK. LOCK_TICKS is unused.

## Test plan
- Reset, iGenDone at cycle 3, no overlap → oResetPiecePosition cycle 4, oUpdatePiece cycle 6, iUpdateDone → IDLE, oIndex=0.
- BAG_SIZE=4, landed with a tick each IDLE visit, no lock delay, 4 locks → oIndex 0,1,2,3, then GEN with oIndex=0, oPiecesPlaced=4, oGeneratePieceOrder reasserted.
- iPieceBlockOverlap=1 in CHECK → oGameOver=1 sticky for 50 cycles with requests toggling; iReset → oGameOver=0, state GEN.
- iMoveLeft and iGravityTick in the same IDLE cycle → oUpdatePiece, oGravityDrop=0; next tick with iLanded=0 → oGravityDrop=1 for one cycle.
- GL_LOCK_DELAY_EN, LOCK_TICKS=2, landed:
  - tick, then iRotate, then tick → no lock;
  - a further tick → oLockPiece=1.
- iEn low for 10 cycles mid-UPDATE with iUpdateDone=1 → no transition, oUpdatePiece=0; iEn high → IDLE next edge.

Source files
------------

// File: rtl/game_loop_seq.sv
// Game-loop sequencer: walks a generated piece bag, spawns pieces, arbitrates moves vs gravity, commands locks.
// Optional lock delay enabled by defining GL_LOCK_DELAY_EN.
module game_loop_seq #(
  parameter int BAG_SIZE   = 7,
  parameter int INDEX_W    = 3,
  parameter int LOCK_TICKS = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               iReset,
  input  logic               iEn,
  input  logic               iMoveRight,
  input  logic               iMoveLeft,
  input  logic               iMoveDown,
  input  logic               iRotate,
  input  logic               iGravityTick,
  input  logic               iLanded,
  input  logic               iPieceBlockOverlap,
  input  logic               iGenDone,
  input  logic               iUpdateDone,
  output logic               oGeneratePieceOrder,
  output logic               oResetPiecePosition,
  output logic               oUpdatePiece,
  output logic               oGravityDrop,
  output logic               oLockPiece,
  output logic [INDEX_W-1:0] oIndex,
  output logic [CNT_W-1:0]   oPiecesPlaced,
  output logic               oGameOver
);

  typedef enum logic [2:0] {GEN, SPAWN, CHECK, UPDATE, IDLE, LOCK, ADVANCE, OVER} state_t;

  state_t state, state_nxt;
  logic   move_req, lock_go, bag_end, act;

  assign move_req = iMoveRight | iMoveLeft | iMoveDown | iRotate;
  assign bag_end  = (oIndex == INDEX_W'(BAG_SIZE - 1));
  // Request outputs are suppressed while frozen or held in reset.
  assign act      = iEn & ~iReset;

`ifdef GL_LOCK_DELAY_EN
  localparam int LOCK_W = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS) : 1;
  logic [LOCK_W-1:0] lock_cnt;

  assign lock_go = (lock_cnt == LOCK_W'(LOCK_TICKS - 1));

  always_ff @(posedge clk) begin
    if (iReset)
      lock_cnt <= '0;
    else if (iEn) begin
      if (state == ADVANCE)
        lock_cnt <= '0;
      else if (state == IDLE) begin
        if (move_req || !iLanded)
          lock_cnt <= '0;
        else if (iGravityTick && !lock_go)
          lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end
`else
  // Without a delay the first landed tick locks (LOCK_TICKS >= 1 always holds).
  assign lock_go = (LOCK_TICKS > 0);
`endif

  always_ff @(posedge clk) begin
    if (iReset)
      state <= GEN;
    else if (iEn)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      GEN:     if (iGenDone) state_nxt = SPAWN;
      SPAWN:   state_nxt = CHECK;
      CHECK:   state_nxt = iPieceBlockOverlap ? OVER : UPDATE;
      UPDATE:  if (iUpdateDone) state_nxt = IDLE;
      IDLE: begin
        if (move_req)
          state_nxt = UPDATE;
        else if (iGravityTick && !iLanded)
          state_nxt = UPDATE;
        else if (iGravityTick && iLanded && lock_go)
          state_nxt = LOCK;
      end
      LOCK:    if (iUpdateDone) state_nxt = ADVANCE;
      ADVANCE: state_nxt = bag_end ? GEN : SPAWN;
      OVER:    state_nxt = OVER;
      default: state_nxt = GEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      oIndex        <= '0;
      oPiecesPlaced <= '0;
    end else if (iEn && state == ADVANCE) begin
      oPiecesPlaced <= oPiecesPlaced + 1'b1;
      oIndex        <= bag_end ? '0 : oIndex + 1'b1;
    end
  end

  always_comb begin
    oGeneratePieceOrder = 1'b0;
    oResetPiecePosition = 1'b0;
    oUpdatePiece        = 1'b0;
    oLockPiece          = 1'b0;
    oGravityDrop        = 1'b0;
    if (act) begin
      case (state)
        GEN:    oGeneratePieceOrder = 1'b1;
        SPAWN:  oResetPiecePosition = 1'b1;
        UPDATE: oUpdatePiece        = 1'b1;
        LOCK:   oLockPiece          = 1'b1;
        IDLE:   oGravityDrop        = ~move_req & iGravityTick & ~iLanded;
        default: ;
      endcase
    end
  end

  assign oGameOver = (state == OVER);

endmodule

// File: tb/tb_game_loop_seq.sv
// Scoreboard bench for game_loop_seq: stimulus pushes per-cycle expected outputs, a monitor pops and compares.
module tb_game_loop_seq;

  typedef struct packed {
    logic        gen, spawn, upd, gdrop, lock, over;
    logic [2:0]  idx;
    logic [15:0] placed;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic iReset, iEn, iMoveRight, iMoveLeft, iMoveDown, iRotate;
  logic iGravityTick, iLanded, iPieceBlockOverlap, iGenDone, iUpdateDone;
  logic oGeneratePieceOrder, oResetPiecePosition, oUpdatePiece, oGravityDrop, oLockPiece, oGameOver;
  logic [2:0]  oIndex;
  logic [15:0] oPiecesPlaced;

  game_loop_seq #(.BAG_SIZE(4), .INDEX_W(3), .LOCK_TICKS(2), .CNT_W(16)) dut (
    .clk(clk), .iReset(iReset), .iEn(iEn),
    .iMoveRight(iMoveRight), .iMoveLeft(iMoveLeft), .iMoveDown(iMoveDown), .iRotate(iRotate),
    .iGravityTick(iGravityTick), .iLanded(iLanded), .iPieceBlockOverlap(iPieceBlockOverlap),
    .iGenDone(iGenDone), .iUpdateDone(iUpdateDone),
    .oGeneratePieceOrder(oGeneratePieceOrder), .oResetPiecePosition(oResetPiecePosition),
    .oUpdatePiece(oUpdatePiece), .oGravityDrop(oGravityDrop), .oLockPiece(oLockPiece),
    .oIndex(oIndex), .oPiecesPlaced(oPiecesPlaced), .oGameOver(oGameOver)
  );

  obs_t  act;
  assign act = {oGeneratePieceOrder, oResetPiecePosition, oUpdatePiece, oGravityDrop,
                oLockPiece, oGameOver, oIndex, oPiecesPlaced};

  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    idx_e = 0;
  int    placed_e = 0;
  int    q_cyc[$];
  obs_t  q_exp[$];
  string q_name[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(logic gen, logic sp, logic up, logic gd, logic lk, logic ov);
    obs_t r;
    r = {gen, sp, up, gd, lk, ov, 3'(idx_e), 16'(placed_e)};
    return r;
  endfunction

  task automatic chk(string nm, obs_t e);
    q_cyc.push_back(cyc);
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic step(string nm, obs_t e);
    chk(nm, e);
    nxt();
  endtask

  // Monitor: compares the DUT outputs against the queued expectation for this cycle.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never sampled", q_name[0], q_cyc[0]);
      void'(q_cyc.pop_front());
      void'(q_exp.pop_front());
      void'(q_name.pop_front());
    end
    if (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
      checks++;
      if (act !== q_exp[0]) begin
        errors++;
        $display("FAIL %s: cycle %0d got %h want %h", q_name[0], cyc, act, q_exp[0]);
      end
      void'(q_cyc.pop_front());
      void'(q_exp.pop_front());
      void'(q_name.pop_front());
    end
  end

  task automatic spawn_to_idle();
    step("spawn", mk(0, 1, 0, 0, 0, 0));
    iPieceBlockOverlap = 1'b0;
    step("check", mk(0, 0, 0, 0, 0, 0));
    iUpdateDone = 1'b1;
    step("spawn_upd", mk(0, 0, 1, 0, 0, 0));
    iUpdateDone = 1'b0;
  endtask

  task automatic finish_lock();
    iUpdateDone = 1'b1;
    step("lock_done", mk(0, 0, 0, 0, 1, 0));
    iUpdateDone = 1'b0;
    iLanded = 1'b0;
    step("advance", mk(0, 0, 0, 0, 0, 0));
    placed_e++;
    idx_e = (idx_e == 3) ? 0 : idx_e + 1;
  endtask

  task automatic lock_piece();
    iLanded = 1'b1;
`ifdef GL_LOCK_DELAY_EN
    iGravityTick = 1'b1;
    step("tick_wait", mk(0, 0, 0, 0, 0, 0));
`endif
    iGravityTick = 1'b1;
    step("tick_lock", mk(0, 0, 0, 0, 0, 0));
    iGravityTick = 1'b0;
    step("lock", mk(0, 0, 0, 0, 1, 0));
    finish_lock();
  endtask

  initial begin
    iReset = 1'b1; iEn = 1'b1;
    iMoveRight = 1'b0; iMoveLeft = 1'b0; iMoveDown = 1'b0; iRotate = 1'b0;
    iGravityTick = 1'b0; iLanded = 1'b0; iPieceBlockOverlap = 1'b0;
    iGenDone = 1'b0; iUpdateDone = 1'b0;
    nxt();
    step("reset", mk(0, 0, 0, 0, 0, 0));
    iReset = 1'b0;

    // Generation handshake, iGenDone in the fourth cycle after reset release.
    for (int i = 0; i < 3; i++) step("gen", mk(1, 0, 0, 0, 0, 0));
    iGenDone = 1'b1;
    step("gen_done", mk(1, 0, 0, 0, 0, 0));
    iGenDone = 1'b0;
    spawn_to_idle();
    step("idle", mk(0, 0, 0, 0, 0, 0));

    // Move beats a simultaneous tick; a later free tick is a gravity drop.
    iMoveLeft = 1'b1; iGravityTick = 1'b1;
    step("move_vs_tick", mk(0, 0, 0, 0, 0, 0));
    iMoveLeft = 1'b0; iGravityTick = 1'b0;
    step("move_upd", mk(0, 0, 1, 0, 0, 0));
    iUpdateDone = 1'b1;
    step("move_done", mk(0, 0, 1, 0, 0, 0));
    iUpdateDone = 1'b0;
    iGravityTick = 1'b1; iLanded = 1'b0;
    step("gdrop", mk(0, 0, 0, 1, 0, 0));
    iGravityTick = 1'b0;
    step("gdrop_upd", mk(0, 0, 1, 0, 0, 0));

    // Freeze in UPDATE with iUpdateDone held.
    iEn = 1'b0; iUpdateDone = 1'b1;
    for (int i = 0; i < 10; i++) step("en_low", mk(0, 0, 0, 0, 0, 0));
    iEn = 1'b1;
    step("en_high", mk(0, 0, 1, 0, 0, 0));
    iUpdateDone = 1'b0;
    step("idle_after_en", mk(0, 0, 0, 0, 0, 0));

    // Full bag of four locks, then a fresh bag.
    for (int p = 0; p < 4; p++) begin
      lock_piece();
      if (p < 3) spawn_to_idle();
    end
    step("bag_regen", mk(1, 0, 0, 0, 0, 0));
    iGenDone = 1'b1;
    step("gen_done2", mk(1, 0, 0, 0, 0, 0));
    iGenDone = 1'b0;
    spawn_to_idle();

    iLanded = 1'b1;
`ifdef GL_LOCK_DELAY_EN
    iGravityTick = 1'b1;
    step("ld_tick1", mk(0, 0, 0, 0, 0, 0));
    iGravityTick = 1'b0; iRotate = 1'b1;
    step("ld_rotate", mk(0, 0, 0, 0, 0, 0));
    iRotate = 1'b0; iUpdateDone = 1'b1;
    step("ld_rot_upd", mk(0, 0, 1, 0, 0, 0));
    iUpdateDone = 1'b0; iGravityTick = 1'b1;
    step("ld_tick2", mk(0, 0, 0, 0, 0, 0));
    iGravityTick = 1'b0;
    step("ld_no_lock", mk(0, 0, 0, 0, 0, 0));
    iGravityTick = 1'b1;
    step("ld_tick3", mk(0, 0, 0, 0, 0, 0));
`else
    iGravityTick = 1'b1;
    step("first_tick", mk(0, 0, 0, 0, 0, 0));
`endif
    iGravityTick = 1'b0;
    step("lock_entry", mk(0, 0, 0, 0, 1, 0));
    finish_lock();

    // Overlapping spawn ends the game; requests are ignored until reset.
    step("spawn_ovl", mk(0, 1, 0, 0, 0, 0));
    iPieceBlockOverlap = 1'b1;
    step("check_ovl", mk(0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 50; i++) begin
      iMoveRight = i[0]; iRotate = i[1]; iGravityTick = i[0];
      iLanded = i[2]; iGenDone = i[1]; iUpdateDone = i[0];
      step("over", mk(0, 0, 0, 0, 0, 1));
    end
    iMoveRight = 1'b0; iRotate = 1'b0; iGravityTick = 1'b0; iLanded = 1'b0;
    iGenDone = 1'b0; iUpdateDone = 1'b0; iPieceBlockOverlap = 1'b0;
    iReset = 1'b1;
    nxt();
    iReset = 1'b0;
    idx_e = 0; placed_e = 0;
    step("after_reset", mk(1, 0, 0, 0, 0, 0));

    nxt();
    nxt();
    if (q_cyc.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q_cyc.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
